// File: rtl/single_port_ram_async.sv
// Single-port RAM: level-sensitive (latch) write, combinational read with write-through.
// Define RAM_REG_OUT_EN to register data_out on posedge clk (one cycle of read latency).
module single_port_ram_async #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mode,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_in_range;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_data;

    // A full address space needs no range compare.
    generate
        if (DEPTH < (2 ** ADDR_W)) begin : g_range
            assign w_in_range = (addr < ADDR_W'(DEPTH));
        end else begin : g_full
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_wr_en = rst_n & mode & w_in_range;

    // Each word is a transparent latch: it tracks data_in while addressed and write-enabled.
    always_latch begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[addr] <= data_in;
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (!rst_n) begin
            w_rd_data = '0;
        end else if (mode) begin
            w_rd_data = data_in;
        end else if (w_in_range) begin
            w_rd_data = r_mem[addr];
        end
    end

`ifdef RAM_REG_OUT_EN
    logic [DATA_W-1:0] r_dout_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_p1 <= '0;
        end else begin
            r_dout_p1 <= w_rd_data;
        end
    end

    assign data_out = r_dout_p1;
`else
    logic w_unused_clk;

    assign w_unused_clk = clk;
    assign data_out     = w_rd_data;
`endif

endmodule

// File: tb/tb_single_port_ram_async.sv
// Scoreboard bench for single_port_ram_async: full-depth instance plus a DEPTH=40 instance for range checks.
// A behavioural array model predicts data_out; a monitor pops expectations and compares.
module tb_single_port_ram_async;

    localparam int DW     = 8;
    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int DEPTH2 = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr;
    logic          mode;
    logic [DW-1:0] data_out;
    logic [DW-1:0] data_out2;

    always #5 clk = ~clk;

    single_port_ram_async #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr), .mode(mode), .data_out(data_out)
    );

    single_port_ram_async #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr), .mode(mode), .data_out(data_out2)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } exp_t;

    exp_t          sb_q[$];
    event          ev_sample;
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;

    // Expected data_out for a RAM of the given depth under the current inputs.
    function automatic logic [DW-1:0] model_out(int depth, logic rn, logic m, logic [AW-1:0] a,
                                                logic [DW-1:0] d);
        if (!rn) return '0;
        if (m) return d;
        if (int'(a) >= depth) return '0;
        return ref_mem[a];
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (mode) begin
            ref_mem[addr] = data_in;
        end
    endtask

    task automatic push(string nm, logic [DW-1:0] e1, logic [DW-1:0] e2);
        exp_t e;
        e.name = nm;
        e.exp1 = e1;
        e.exp2 = e2;
        sb_q.push_back(e);
        ->ev_sample;
        #1;
    endtask

    task automatic apply(string nm, logic rn, logic m, logic [AW-1:0] a, logic [DW-1:0] d);
`ifdef RAM_REG_OUT_EN
        @(negedge clk);
`endif
        rst_n   = rn;
        mode    = m;
        addr    = a;
        data_in = d;
        model_update();
        #1;
`ifdef RAM_REG_OUT_EN
        if (!rn) begin
            last1 = '0;
            last2 = '0;
        end
        push({nm, "_pre_edge"}, last1, last2);
        @(posedge clk);
        #1;
`endif
        last1 = model_out(DEPTH, rn, m, a, d);
        last2 = model_out(DEPTH2, rn, m, a, d);
        push(nm, last1, last2);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: sample event with no expectation queued");
            end else begin
                e = sb_q.pop_front();
                if (data_out === e.exp1 && data_out2 === e.exp2) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %h/%h required %h/%h (addr=%0d mode=%0b rst_n=%0b)",
                             e.name, data_out, data_out2, e.exp1, e.exp2, addr, mode, rst_n);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        mode    = 1'b1;
        addr    = 6'd5;
        data_in = 8'hAA;

        apply("reset_hold_write", 1'b0, 1'b1, 6'd5, 8'hAA);
        apply("reset_release_rd5", 1'b1, 1'b0, 6'd5, 8'h00);
        for (int i = 0; i < DEPTH; i++) apply("reset_all_zero", 1'b1, 1'b0, AW'(i), 8'h00);

        for (int i = 0; i < DEPTH; i++) apply("fill_write", 1'b1, 1'b1, AW'(i), DW'(i + 5));
        for (int i = 0; i < DEPTH; i++) apply("fill_readback", 1'b1, 1'b0, AW'(i), 8'h00);

        apply("write_through", 1'b1, 1'b1, 6'd10, 8'h3C);
        apply("write_through_rd", 1'b1, 1'b0, 6'd10, 8'h3C);

        apply("ovw_neigh", 1'b1, 1'b1, 6'd6, 8'h55);
        apply("ovw_first", 1'b1, 1'b1, 6'd7, 8'h11);
        apply("ovw_second", 1'b1, 1'b1, 6'd7, 8'hEE);
        apply("ovw_rd7", 1'b1, 1'b0, 6'd7, 8'hEE);
        apply("ovw_rd6", 1'b1, 1'b0, 6'd6, 8'h00);

        apply("range_wr39", 1'b1, 1'b1, 6'd39, 8'h99);
        apply("range_wr40", 1'b1, 1'b1, 6'd40, 8'h66);
        apply("range_wr63", 1'b1, 1'b1, 6'd63, 8'h77);
        apply("range_rd39", 1'b1, 1'b0, 6'd39, 8'h00);
        apply("range_rd40", 1'b1, 1'b0, 6'd40, 8'h00);
        apply("range_rd63", 1'b1, 1'b0, 6'd63, 8'h00);

        apply("reg_wr3", 1'b1, 1'b1, 6'd3, 8'h42);
        apply("reg_rd2", 1'b1, 1'b0, 6'd2, 8'h00);
        apply("reg_rd3", 1'b1, 1'b0, 6'd3, 8'h00);

        apply("mid_reset", 1'b0, 1'b0, 6'd20, 8'h00);
        apply("post_reset_rd20", 1'b1, 1'b0, 6'd20, 8'h00);
        apply("post_reset_rd63", 1'b1, 1'b0, 6'd63, 8'h00);

        for (int n = 0; n < 400; n++) begin
            apply("random", ($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        end

        for (int k = 0; k < 100 && sb_q.size() != 0; k++) #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
